// File: rtl/loop_predictor.sv
// Tagged loop-exit predictor: learns backward-branch trip counts at EX and
// overrides the fetch-stage direction once the trip count has repeated enough.
module loop_predictor #(
  parameter int WIDTH     = 32,
  parameter int IDX_BITS  = 6,
  parameter int TAG_BITS  = 8,
  parameter int CNT_BITS  = 10,
  parameter int CONF_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             lk_valid_i,
  input  logic [WIDTH-1:0] lk_pc_i,
  input  logic [WIDTH-1:0] lk_target_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  input  logic             upd_valid_i,
  input  logic [WIDTH-1:0] upd_pc_i,
  input  logic [WIDTH-1:0] upd_target_i,
  input  logic             upd_taken_i,
  output logic             upd_mispredict_o
);

  localparam int ENTRIES = 2 ** IDX_BITS;
  localparam logic [CONF_BITS-1:0] CONF_MAX = {CONF_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0]  CNT_MAX  = {CNT_BITS{1'b1}};

  logic                valid_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [ENTRIES];
  logic [CNT_BITS-1:0] trip_q  [ENTRIES];
  logic [CNT_BITS-1:0] iter_q  [ENTRIES];
  logic [CONF_BITS-1:0] conf_q [ENTRIES];
  logic                mispredict_q;

  logic [IDX_BITS-1:0] lk_idx, upd_idx;
  logic [TAG_BITS-1:0] lk_tag, upd_tag;
  logic                lk_hit, upd_en, upd_hit;

  logic                e_we;
  logic                e_valid_d;
  logic [TAG_BITS-1:0] e_tag_d;
  logic [CNT_BITS-1:0] e_trip_d, e_iter_d;
  logic [CONF_BITS-1:0] e_conf_d;
  logic                mispredict_d;

  assign lk_idx  = lk_pc_i[IDX_BITS+1:2];
  assign lk_tag  = lk_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign upd_idx = upd_pc_i[IDX_BITS+1:2];
  assign upd_tag = upd_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Lookup reads the pre-update table; no bypass from a same-cycle update.
  always_comb begin
    lk_hit       = lk_valid_i && (lk_target_i < lk_pc_i) &&
                   valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_valid_o = lk_hit && (conf_q[lk_idx] == CONF_MAX);
    pred_taken_o = pred_valid_o && (iter_q[lk_idx] != trip_q[lk_idx]);
  end

  always_comb begin
    upd_en       = upd_valid_i && (upd_target_i < upd_pc_i);
    upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    e_we         = 1'b0;
    e_valid_d    = valid_q[upd_idx];
    e_tag_d      = tag_q[upd_idx];
    e_trip_d     = trip_q[upd_idx];
    e_iter_d     = iter_q[upd_idx];
    e_conf_d     = conf_q[upd_idx];
    mispredict_d = 1'b0;
    if (upd_en) begin
      if (!upd_hit) begin
        if (upd_taken_i) begin
          e_we      = 1'b1;
          e_valid_d = 1'b1;
          e_tag_d   = upd_tag;
          e_trip_d  = '0;
          e_iter_d  = CNT_BITS'(1);
          e_conf_d  = '0;
        end
      end else if (upd_taken_i) begin
        e_we = 1'b1;
        // A loop longer than the counter can express is not worth tracking.
        if (iter_q[upd_idx] == CNT_MAX) e_valid_d = 1'b0;
        else                            e_iter_d  = iter_q[upd_idx] + CNT_BITS'(1);
        if ((conf_q[upd_idx] == CONF_MAX) && (iter_q[upd_idx] == trip_q[upd_idx])) begin
          mispredict_d = 1'b1;
          e_conf_d     = '0;
        end
      end else begin
        e_we     = 1'b1;
        e_iter_d = '0;
        if (iter_q[upd_idx] == trip_q[upd_idx]) begin
          if (conf_q[upd_idx] != CONF_MAX) e_conf_d = conf_q[upd_idx] + CONF_BITS'(1);
        end else begin
          e_trip_d     = iter_q[upd_idx];
          e_conf_d     = '0;
          mispredict_d = (conf_q[upd_idx] == CONF_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        trip_q[i]  <= '0;
        iter_q[i]  <= '0;
        conf_q[i]  <= '0;
      end
      mispredict_q <= 1'b0;
    end else if (clear_i) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      mispredict_q <= mispredict_d;
      if (e_we) begin
        valid_q[upd_idx] <= e_valid_d;
        tag_q[upd_idx]   <= e_tag_d;
        trip_q[upd_idx]  <= e_trip_d;
        iter_q[upd_idx]  <= e_iter_d;
        conf_q[upd_idx]  <= e_conf_d;
      end
    end
  end

  assign upd_mispredict_o = mispredict_q;

endmodule

// File: tb/tb_loop_predictor.sv
// Directed bench for loop_predictor: learning, confidence, mispredict, gating,
// aliasing, clear, reset and counter-overflow behaviour (second instance, CNT_BITS=4).
module tb_loop_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        lk_valid, upd_valid, upd_taken;
  logic [31:0] lk_pc, lk_target, upd_pc, upd_target;
  logic        pred_valid, pred_taken, upd_mispredict;

  logic        lk4_valid, u4_valid, u4_taken;
  logic [31:0] lk4_pc, lk4_target, u4_pc, u4_target;
  logic        p4_valid, p4_taken, m4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  loop_predictor dut (
    .clk(clk), .rst(rst), .clear_i(clear),
    .lk_valid_i(lk_valid), .lk_pc_i(lk_pc), .lk_target_i(lk_target),
    .pred_valid_o(pred_valid), .pred_taken_o(pred_taken),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_target_i(upd_target),
    .upd_taken_i(upd_taken), .upd_mispredict_o(upd_mispredict)
  );

  loop_predictor #(.CNT_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .clear_i(1'b0),
    .lk_valid_i(lk4_valid), .lk_pc_i(lk4_pc), .lk_target_i(lk4_target),
    .pred_valid_o(p4_valid), .pred_taken_o(p4_taken),
    .upd_valid_i(u4_valid), .upd_pc_i(u4_pc), .upd_target_i(u4_target),
    .upd_taken_i(u4_taken), .upd_mispredict_o(m4)
  );

  task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic do_upd4(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    @(negedge clk);
    u4_valid = 1'b1; u4_pc = pc; u4_target = tgt; u4_taken = tk;
    @(posedge clk); #1;
    u4_valid = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input logic [31:0] tgt);
    lk_valid = 1'b1; lk_pc = pc; lk_target = tgt;
    #1;
  endtask

  task automatic loop_pass(input logic [31:0] pc, input logic [31:0] tgt, input int n_taken);
    for (int i = 0; i < n_taken; i++) do_upd(pc, tgt, 1'b1);
    do_upd(pc, tgt, 1'b0);
  endtask

  task automatic test_reset;
    look(32'h100, 32'h0F0);
    checks++;
    if (pred_valid !== 1'b0 || pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_lookup: pred_valid=%b pred_taken=%b, expected 0 0", pred_valid, pred_taken);
    end
    checks++;
    if (upd_mispredict !== 1'b0) begin
      errors++;
      $display("FAIL reset_mispredict: got %b expected 0", upd_mispredict);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    look(32'h100, 32'h0F0);
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_lookup: pred_valid=%b expected 0", pred_valid);
    end
  endtask

  task automatic test_learn;
    loop_pass(32'h100, 32'h0F0, 4);
    look(32'h100, 32'h0F0);
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL learn_pass1: pred_valid=%b expected 0", pred_valid);
    end
    loop_pass(32'h100, 32'h0F0, 4);
    loop_pass(32'h100, 32'h0F0, 4);
    look(32'h100, 32'h0F0);
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL learn_pass3: pred_valid=%b expected 0", pred_valid);
    end
    loop_pass(32'h100, 32'h0F0, 4);
    for (int i = 0; i < 4; i++) begin
      look(32'h100, 32'h0F0);
      checks++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin
        errors++;
        $display("FAIL pass5_iter%0d: pred_valid=%b pred_taken=%b expected 1 1", i, pred_valid, pred_taken);
      end
      do_upd(32'h100, 32'h0F0, 1'b1);
    end
    look(32'h100, 32'h0F0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL pass5_exit: pred_valid=%b pred_taken=%b expected 1 0", pred_valid, pred_taken);
    end
    do_upd(32'h100, 32'h0F0, 1'b0);
    checks++;
    if (upd_mispredict !== 1'b0) begin
      errors++;
      $display("FAIL pass5_no_mispredict: got %b expected 0", upd_mispredict);
    end
  endtask

  task automatic test_forward;
    look(32'h100, 32'h140);
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL fwd_lookup: pred_valid=%b expected 0", pred_valid);
    end
    look(32'h100, 32'h100);
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL equal_target_lookup: pred_valid=%b expected 0", pred_valid);
    end
    for (int i = 0; i < 5; i++) do_upd(32'h100, 32'h140, 1'b1);
    checks++;
    if (upd_mispredict !== 1'b0) begin
      errors++;
      $display("FAIL fwd_update_mispredict: got %b expected 0", upd_mispredict);
    end
    for (int i = 0; i < 10; i++) do_upd(32'h200, 32'h240, 1'b1);
    look(32'h200, 32'h240);
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL fwd_no_alloc: pred_valid=%b expected 0", pred_valid);
    end
    look(32'h100, 32'h0F0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL fwd_entry_intact: pred_valid=%b pred_taken=%b expected 1 1", pred_valid, pred_taken);
    end
  endtask

  task automatic test_mispredict;
    for (int i = 0; i < 4; i++) do_upd(32'h100, 32'h0F0, 1'b1);
    do_upd(32'h100, 32'h0F0, 1'b1);
    checks++;
    if (upd_mispredict !== 1'b1) begin
      errors++;
      $display("FAIL taken_mispredict: got %b expected 1", upd_mispredict);
    end
    @(posedge clk); #1;
    checks++;
    if (upd_mispredict !== 1'b0) begin
      errors++;
      $display("FAIL mispredict_one_cycle: got %b expected 0", upd_mispredict);
    end
    look(32'h100, 32'h0F0);
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL conf_reset: pred_valid=%b expected 0", pred_valid);
    end
    do_upd(32'h100, 32'h0F0, 1'b1);
    do_upd(32'h100, 32'h0F0, 1'b0);
    checks++;
    if (upd_mispredict !== 1'b0) begin
      errors++;
      $display("FAIL retrain_exit: got %b expected 0", upd_mispredict);
    end
    for (int p = 0; p < 3; p++) loop_pass(32'h100, 32'h0F0, 6);
    for (int i = 0; i < 5; i++) do_upd(32'h100, 32'h0F0, 1'b1);
    look(32'h100, 32'h0F0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL trip6_iter5: pred_valid=%b pred_taken=%b expected 1 1", pred_valid, pred_taken);
    end
    do_upd(32'h100, 32'h0F0, 1'b1);
    look(32'h100, 32'h0F0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL trip6_exit: pred_valid=%b pred_taken=%b expected 1 0", pred_valid, pred_taken);
    end
    do_upd(32'h100, 32'h0F0, 1'b0);
    // Early exit at iter 3 against a confident trip of 6.
    for (int i = 0; i < 3; i++) do_upd(32'h100, 32'h0F0, 1'b1);
    do_upd(32'h100, 32'h0F0, 1'b0);
    checks++;
    if (upd_mispredict !== 1'b1) begin
      errors++;
      $display("FAIL early_exit_mispredict: got %b expected 1", upd_mispredict);
    end
    look(32'h100, 32'h0F0);
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_exit_conf: pred_valid=%b expected 0", pred_valid);
    end
  endtask

  task automatic test_clear;
    for (int p = 0; p < 3; p++) loop_pass(32'h100, 32'h0F0, 3);
    for (int i = 0; i < 3; i++) do_upd(32'h100, 32'h0F0, 1'b1);
    look(32'h100, 32'h0F0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL trip3_exit: pred_valid=%b pred_taken=%b expected 1 0", pred_valid, pred_taken);
    end
    @(negedge clk);
    clear = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_target = 32'h0F0; upd_taken = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; upd_valid = 1'b0;
    checks++;
    if (upd_mispredict !== 1'b0) begin
      errors++;
      $display("FAIL clear_drops_update: mispredict=%b expected 0", upd_mispredict);
    end
    look(32'h100, 32'h0F0);
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_invalidates: pred_valid=%b expected 0", pred_valid);
    end
  endtask

  task automatic test_alias;
    for (int p = 0; p < 4; p++) loop_pass(32'h100, 32'h0F0, 2);
    look(32'h100, 32'h0F0);
    checks++;
    if (pred_valid !== 1'b1) begin
      errors++;
      $display("FAIL alias_learn: pred_valid=%b expected 1", pred_valid);
    end
    do_upd(32'h200, 32'h1F0, 1'b1);
    look(32'h100, 32'h0F0);
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL alias_evict: pred_valid=%b expected 0", pred_valid);
    end
    look(32'h200, 32'h1F0);
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL alias_new_unconfident: pred_valid=%b expected 0", pred_valid);
    end
  endtask

  task automatic test_reset_mid_loop;
    do_upd(32'h200, 32'h1F0, 1'b1);
    do_upd(32'h200, 32'h1F0, 1'b0);
    for (int p = 0; p < 3; p++) loop_pass(32'h200, 32'h1F0, 2);
    look(32'h200, 32'h1F0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL relearn_0x200: pred_valid=%b pred_taken=%b expected 1 1", pred_valid, pred_taken);
    end
    do_upd(32'h200, 32'h1F0, 1'b1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    look(32'h200, 32'h1F0);
    checks++;
    if (pred_valid !== 1'b0 || upd_mispredict !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_loop: pred_valid=%b mispredict=%b expected 0 0", pred_valid, upd_mispredict);
    end
  endtask

  task automatic test_cnt_overflow;
    lk4_valid = 1'b1; lk4_pc = 32'h100; lk4_target = 32'h0F0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 2; i++) do_upd4(32'h100, 32'h0F0, 1'b1);
      do_upd4(32'h100, 32'h0F0, 1'b0);
    end
    #1;
    checks++;
    if (p4_valid !== 1'b1) begin
      errors++;
      $display("FAIL cnt4_learn: pred_valid=%b expected 1", p4_valid);
    end
    for (int i = 0; i < 16; i++) do_upd4(32'h100, 32'h0F0, 1'b1);
    // A surviving entry would regain confidence from these exits at iter 0.
    for (int i = 0; i < 4; i++) do_upd4(32'h100, 32'h0F0, 1'b0);
    #1;
    checks++;
    if (p4_valid !== 1'b0) begin
      errors++;
      $display("FAIL cnt4_overflow_invalidate: pred_valid=%b expected 0", p4_valid);
    end
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0;
    lk_valid = 1'b0; lk_pc = '0; lk_target = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
    lk4_valid = 1'b0; lk4_pc = '0; lk4_target = '0;
    u4_valid = 1'b0; u4_pc = '0; u4_target = '0; u4_taken = 1'b0;
    #2;
    test_reset;
    test_learn;
    test_forward;
    test_mispredict;
    test_clear;
    test_alias;
    test_reset_mid_loop;
    test_cnt_overflow;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
